pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 8, multiply/divide busy cycles; legal range 2..255.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 id_rs  input  5  rs field of the instruction in ID.
REQ-005 id_rt  input  5  rt field of the instruction in ID.
REQ-006 id_uses_rs  input  1  ID instruction reads rs.
REQ-007 id_uses_rt  input  1  ID instruction reads rt.
REQ-008 ex_mem_read  input  1  instruction in EX is a load.
REQ-009 ex_rt  input  5  load destination register in EX.
REQ-010 id_branch_taken  input  1  branch or jump resolved taken in ID.
REQ-011 id_md  input  1  ID instruction is a multiply/divide.
REQ-012 pc_ld  output  1  PC load enable.
REQ-013 ifid_ld  output  1  IF/ID register load enable.
REQ-014 ifid_flush  output  1  IF/ID register flush; clears the fetched instruction to 0.
REQ-015 idex_bubble  output  1  inject a NOP into ID/EX this cycle.
REQ-016 md_go  output  1  one-cycle start pulse to the multiply/divide unit.
REQ-017 md_wb  output  1  multiply/divide result valid; ID instruction advances this cycle.
REQ-018 busy  output  1  high whenever state is not RUN.
REQ-019 stall_cnt  output  16  count of cycles with pc_ld=0.

Function
REQ-020 Load-use hazard (lu) SHALL be the combinational term: ex_mem_read and ex_rt!=0 and ((id_uses_rs and ex_rt==id_rs) or (id_uses_rt and ex_rt==id_rt)).
REQ-021 The FSM SHALL have exactly three states: RUN, MD_BUSY and MD_DONE.
REQ-022 In RUN with lu=1, the outputs SHALL be pc_ld=0, ifid_ld=0, idex_bubble=1 and ifid_flush=0; state stays RUN; id_branch_taken and id_md are ignored that cycle.
REQ-023 In RUN with lu=0 and id_md=1, the outputs SHALL be md_go=1, pc_ld=0, ifid_ld=0 and idex_bubble=1; the next state is MD_BUSY; the down-counter loads MD_LAT-1.
REQ-024 In RUN with lu=0, id_md=0 and id_branch_taken=1, the outputs SHALL be ifid_flush=1, pc_ld=1 and ifid_ld=1; idex_bubble=0.
REQ-025 In RUN with no condition active, the outputs SHALL be pc_ld=1 and ifid_ld=1; all other outputs are 0.
REQ-026 In MD_BUSY, the outputs SHALL be pc_ld=0, ifid_ld=0 and idex_bubble=1; the counter decrements each cycle.
REQ-027 In MD_BUSY with counter==1, the next state SHALL be MD_DONE; MD_BUSY therefore lasts MD_LAT-1 cycles.
REQ-028 In MD_DONE, the outputs SHALL be md_wb=1, pc_ld=1, ifid_ld=1 and idex_bubble=0; the next state is unconditionally RUN.
REQ-029 id_md in MD_DONE SHALL NOT retrigger; the same instruction is never started twice.
REQ-030 id_branch_taken SHALL be ignored in MD_BUSY and MD_DONE; ifid_flush=0 in those states.
REQ-031 md_go SHALL be high for exactly one cycle per multiply/divide operation.
REQ-032 Total stall for a multiply/divide is MD_LAT cycles with pc_ld=0: 1 cycle in RUN plus MD_LAT-1 cycles in MD_BUSY.
REQ-033 stall_cnt SHALL increment on every clock edge where pc_ld=0 and SHALL saturate at 0xFFFF without wrapping.
REQ-034 busy SHALL be registered-state derived: 1 in MD_BUSY and MD_DONE.

Reset
REQ-035 While rst=1, the state SHALL go to RUN and the counter and stall_cnt SHALL clear to 0.
REQ-036 While rst=1, outputs SHALL be pc_ld=1, ifid_ld=1, ifid_flush=0, idex_bubble=0, md_go=0, md_wb=0 and busy=0, regardless of other inputs.
REQ-037 Reset mid-operation (in MD_BUSY or MD_DONE) SHALL abort the operation; md_wb SHALL NOT assert afterward.

Verification
REQ-038 ex_mem_read=1, ex_rt=5, id_rs=5, id_uses_rs=1 for 1 cycle -> pc_ld=0, ifid_ld=0, idex_bubble=1; stall_cnt=1.
REQ-039 Same as REQ-038 but ex_rt=0 -> no stall: pc_ld=1, idex_bubble=0.
REQ-040 Load-use and id_branch_taken=1 in the same cycle -> stall, ifid_flush=0; next cycle with lu=0 -> ifid_flush=1.
REQ-041 MD_LAT=8, id_md=1 held -> md_go pulse in cycle 0; pc_ld=0 for cycles 0-7; md_wb=1 in cycle 8; next cycle RUN with no second md_go.
REQ-042 rst=1 in the 3rd MD_BUSY cycle -> RUN, busy=0, stall_cnt=0; md_wb stays 0.
REQ-043 Force 70000 stall cycles -> stall_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for a classic 5-stage pipeline. It detects
// load-use hazards between the load in EX and the instruction in ID. It
// flushes IF/ID on taken branches resolved in ID. It also sequences a
// fixed-latency multiply/divide unit with a small three-state FSM.
//
// Parameters
//   MD_LAT          multiply/divide busy cycles (legal range 2..255)
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous, active-high reset
//   id_rs, id_rt    source register fields of the instruction in ID
//   id_uses_rs/rt   ID instruction actually reads rs / rt
//   ex_mem_read     instruction in EX is a load
//   ex_rt           load destination register in EX
//   id_branch_taken branch/jump resolved taken in ID
//   id_md           ID instruction is a multiply/divide
//   pc_ld           PC load enable
//   ifid_ld         IF/ID load enable
//   ifid_flush      clear IF/ID to a NOP
//   idex_bubble     inject a NOP into ID/EX
//   md_go           one-cycle start pulse to the multiply/divide unit
//   md_wb           multiply/divide result valid; ID instruction advances
//   busy            FSM is not in RUN
//   stall_cnt       saturating count of cycles with pc_ld=0
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        id_branch_taken,
  input  logic        id_md,
  output logic        pc_ld,
  output logic        ifid_ld,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_go,
  output logic        md_wb,
  output logic        busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  // The RUN cycle that issues md_go is the first stall cycle. MD_BUSY
  // therefore only covers the remaining MD_LAT-1 cycles.
  localparam logic [7:0] MD_LOAD = 8'(MD_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  md_cnt;
  logic [7:0]  md_cnt_nxt;
  logic        lu;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Register $zero never carries a real dependency, so a load into it
  // cannot cause a hazard.
  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((id_uses_rs && (ex_rt == id_rs)) ||
               (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      md_cnt    <= 8'd0;
      stall_cnt <= 16'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (!pc_ld) begin
        stall_cnt <= sat_inc16(stall_cnt);
      end
    end
  end

  // Reset overrides every output so that the pipeline runs freely and
  // nothing is issued while rst is held. This holds even when the state
  // register still holds a stale MD state on the first reset cycle.
  always_comb begin
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;
    pc_ld       = 1'b1;
    ifid_ld     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_go       = 1'b0;
    md_wb       = 1'b0;
    busy        = 1'b0;

    if (!rst) begin
      busy = (state != RUN);
      case (state)
        RUN: begin
          if (lu) begin
            // Load-use wins. Any branch or md in ID is re-evaluated
            // once the load data is available.
            pc_ld       = 1'b0;
            ifid_ld     = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_md) begin
            md_go       = 1'b1;
            pc_ld       = 1'b0;
            ifid_ld     = 1'b0;
            idex_bubble = 1'b1;
            md_cnt_nxt  = MD_LOAD;
            state_nxt   = MD_BUSY;
          end else if (id_branch_taken) begin
            ifid_flush  = 1'b1;
          end
        end
        MD_BUSY: begin
          pc_ld       = 1'b0;
          ifid_ld     = 1'b0;
          idex_bubble = 1'b1;
          md_cnt_nxt  = md_cnt - 8'd1;
          if (md_cnt == 8'd1) begin
            state_nxt = MD_DONE;
          end
        end
        MD_DONE: begin
          // The md instruction leaves ID this cycle. Returning
          // unconditionally to RUN means it cannot be started again.
          md_wb     = 1'b1;
          state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MD_LAT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, ex_mem_read, id_branch_taken, id_md;
  logic        pc_ld, ifid_ld, ifid_flush, idex_bubble, md_go, md_wb, busy;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state:
  //   md_left = number of cycles until md_wb.
  //   0 means the pipeline is running normally.
  int m_left = 0;
  int m_cnt  = 0;

  // Sampled DUT outputs from the most recent step, in the order
  // {pc_ld, ifid_ld, ifid_flush, idex_bubble, md_go, md_wb, busy}.
  logic [6:0]  s_out;
  logic [15:0] s_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_branch_taken(id_branch_taken), .id_md(id_md),
    .pc_ld(pc_ld), .ifid_ld(ifid_ld), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .md_go(md_go), .md_wb(md_wb),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_lu();
    return ex_mem_read && ex_rt != 0 &&
           ((id_uses_rs && ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
  endfunction

  function automatic logic [6:0] model_out();
    if (rst)             return 7'b1100000;
    if (m_left > 1)      return 7'b0001001;   // waiting on md unit
    if (m_left == 1)     return 7'b1100011;   // result written back
    if (model_lu())      return 7'b0001000;
    if (id_md)           return 7'b0001100;
    if (id_branch_taken) return 7'b1110000;
    return 7'b1100000;
  endfunction

  // One clock cycle. Inputs must already be driven. Outputs are checked
  // at the falling edge, and stall_cnt is checked just after the rising edge.
  task automatic step(input bit en);
    logic [6:0] e;
    @(negedge clk);
    e     = model_out();
    s_out = {pc_ld, ifid_ld, ifid_flush, idex_bubble, md_go, md_wb, busy};
    if (en) chk("outputs", {25'd0, s_out}, {25'd0, e});
    if (rst) begin
      m_left = 0;
      m_cnt  = 0;
    end else begin
      if (m_left > 0) m_left--;
      else if (!model_lu() && id_md) m_left = MD_LAT;
      if (!e[6] && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    #1;
    s_cnt = stall_cnt;
    if (en) chk("stall_cnt", {16'd0, s_cnt}, m_cnt);
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
    id_branch_taken = 0; id_md = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    id_md = 1'b1; id_branch_taken = 1'b1;   // must be ignored under reset
    step(1); step(1);
    chk("rst_pc_ld", s_out[6], 1);
    chk("rst_busy", s_out[0], 0);
    chk("rst_md_go", s_out[2], 0);
    chk("rst_cnt", s_cnt, 0);
    rst = 1'b0;
    idle_inputs();
    step(1);
    chk("run_idle", s_out, 7'b1100000);

    // load-use on rs
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
    step(1);
    chk("lu_pc_ld", s_out[6], 0);
    chk("lu_ifid_ld", s_out[5], 0);
    chk("lu_bubble", s_out[3], 1);
    chk("lu_cnt", s_cnt, 1);

    // load into $zero never stalls
    ex_rt = 0; id_rs = 0;
    step(1);
    chk("r0_pc_ld", s_out[6], 1);
    chk("r0_bubble", s_out[3], 0);

    // load-use beats branch, branch flushes once the hazard clears
    ex_rt = 7; id_rt = 7; id_uses_rt = 1; id_uses_rs = 0; id_branch_taken = 1;
    step(1);
    chk("lubr_pc_ld", s_out[6], 0);
    chk("lubr_flush", s_out[4], 0);
    ex_mem_read = 0;
    step(1);
    chk("br_flush", s_out[4], 1);
    chk("br_pc_ld", s_out[6], 1);

    // multiply/divide sequence
    idle_inputs();
    id_md = 1;
    for (int i = 0; i <= MD_LAT; i++) begin
      step(1);
      chk($sformatf("md%0d_go", i), s_out[2], (i == 0));
      chk($sformatf("md%0d_pc", i), s_out[6], (i == MD_LAT));
      chk($sformatf("md%0d_wb", i), s_out[1], (i == MD_LAT));
      chk($sformatf("md%0d_busy", i), s_out[0], (i >= 1));
      if (i == 3) id_branch_taken = 1;   // ignored while busy
      if (i == 4) chk("md_noflush", s_out[4], 0);
    end
    idle_inputs();
    step(1);
    chk("md_after_go", s_out[2], 0);
    chk("md_after_busy", s_out[0], 0);

    // reset in the third MD_BUSY cycle aborts the operation
    id_md = 1;
    step(1);
    id_md = 0;
    step(1); step(1);
    rst = 1;
    step(1);
    chk("abort_busy", s_out[0], 0);
    chk("abort_cnt", s_cnt, 0);
    rst = 0;
    for (int i = 0; i < MD_LAT + 2; i++) begin
      step(1);
      chk("abort_no_wb", s_out[1], 0);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst             = ($urandom_range(0, 63) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom);
      id_uses_rt      = 1'($urandom);
      ex_mem_read     = 1'($urandom);
      id_branch_taken = 1'($urandom);
      id_md           = ($urandom_range(0, 5) == 0);
      step(1);
    end

    // saturation of the stall counter
    rst = 1; idle_inputs();
    step(1);
    rst = 0;
    ex_mem_read = 1; ex_rt = 3; id_rs = 3; id_uses_rs = 1;
    for (int i = 0; i < 70000; i++) step(0);
    chk("sat_cnt", s_cnt, 16'hFFFF);
    step(1);
    chk("sat_hold", s_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
